fifo_ctrl_block: RTL and testbench
==================================

# fifo_ctrl_block

Single-clock pointer and flag controller for the FIFO memory block (one write port, combinational read port). It owns the write and read addresses, qualifies writes against full, and pops reads against empty. It reports full/empty, programmable almost-full/almost-empty, fill level, and sticky overflow/underflow errors. It sits between the I2C byte engine and the FIFO memory on both TX and RX paths. Read data is first-word-fall-through: the memory output is valid whenever `empty_o` is low.

## Interface
- `addr_size`, default 4: memory address width; depth = 2^addr_size (16 by default).
- `almost_full_level`, default 12: `almost_full_o` asserts when level >= this value. Legal range is 1..depth.
- `almost_empty_level`, default 2: `almost_empty_o` asserts when level <= this value. Legal range is 0..depth-1.

Ports:
- `clock_i`  in  1: single clock; all state updates on its rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `clear_i`  in  1: synchronous flush; same effect as reset, with no other side effects.
- `write_en_i`  in  1: push request from the producer.
- `read_en_i`  in  1: pop request from the consumer.
- `mem_write_en_o`  out  1: drives the memory write enable; equals `write_en_i & ~full_o & ~clear_i`.
- `write_addr_o`  out  addr_size: memory write address (lower bits of the write pointer).
- `read_addr_o`  out  addr_size: memory read address (lower bits of the read pointer).
- `full_o`  out  1: FIFO holds depth entries; also drives the memory full input.
- `empty_o`  out  1: FIFO holds 0 entries.
- `almost_full_o`  out  1: level >= `almost_full_level`.
- `almost_empty_o`  out  1: level <= `almost_empty_level`.
- `level_o`  out  addr_size+1: current entry count, range 0..depth.
- `overflow_o`  out  1: sticky; a push was rejected because the FIFO was full.
- `underflow_o`  out  1: sticky; a pop was rejected because the FIFO was empty.

## Operation
- Pointers:
  - `wptr` and `rptr` are addr_size+1 bits wide; the MSB is the wrap bit.
  - Address outputs are the pointer lower bits.
  - Pointers wrap naturally modulo 2^(addr_size+1).
- Flags and level:
  - `empty_o` = (wptr == rptr).
  - `full_o` = (MSBs differ and lower bits equal).
  - `level_o` = wptr - rptr, taken modulo 2^(addr_size+1).
  - All flags are combinational from the registered pointers; there is no extra flag register.
- Push is accepted when `write_en_i & ~full_o`; `wptr` increments by 1.
- Pop is accepted when `read_en_i & ~empty_o`; `rptr` increments by 1.
- Simultaneous push and pop:
  - Neither full nor empty: both are accepted; level is unchanged; both pointers advance.
  - Full: pop is accepted, push is rejected (memory write is gated by the same full), `overflow_o` sets, and level becomes depth-1.
  - Empty: push is accepted, pop is rejected, `underflow_o` sets, and level becomes 1.
- Sticky errors:
  - `overflow_o` sets on any rejected push; `underflow_o` sets on any rejected pop.
  - Both hold until `reset_i` or `clear_i`.
- Priority: `reset_i` > `clear_i` > push/pop.
  - When `clear_i` is high, pushes and pops in that cycle are discarded.
  - Discarded requests do not set the error flags.
- Memory contents are never cleared; they become stale and unreachable after reset or clear.

## Timing
- Reset and clear values, observed the cycle after the edge where the input is sampled high:
  - `wptr` = `rptr` = 0, so both address outputs are 0.
  - `empty_o`=1, `full_o`=0, `level_o`=0.
  - `almost_empty_o`=1 (since level 0 <= level), `almost_full_o`=0.
  - `overflow_o`=0, `underflow_o`=0.
- Reset or clear asserted mid-stream: takes effect at that edge regardless of pending requests.
- Push latency:
  - Data is written at the edge where the push is accepted.
  - `empty_o` falls and `level_o` updates immediately after that edge.
  - The pushed word appears on the memory read output in the same cycle `empty_o` falls (first-word-fall-through).
- Pop: the consumer samples the memory read data and asserts `read_en_i` in the same cycle; the next word (or `empty_o`=1) appears after the edge.
- Throughput: one push and one pop per cycle, sustained.
- All outputs are stable within a cycle; `mem_write_en_o` depends combinationally on `write_en_i` and `clear_i`.

## Test plan
- **Reset:** hold `reset_i` 2 cycles with random `write_en_i`/`read_en_i` -> `empty_o`=1, `level_o`=0, addresses 0, errors 0.
- **Fill:** 16 consecutive pushes of 0x00..0x0F -> `almost_full_o` rises after the 12th, `full_o` after the 16th, `level_o`=16.
  - A 17th push -> `mem_write_en_o`=0 and `overflow_o`=1.
  - Then drain 16 pops -> data 0x00..0x0F in order, `empty_o`=1.
- **Wrap-around:** 40 cycles of simultaneous push and pop at level 5 -> level stays 5, addresses wrap 15->0, data order preserved, no error flags.
- **Full with push+pop:** at level 16, assert both -> level becomes 15, `overflow_o`=1, the oldest word is popped.
- **Empty with push+pop:** at level 0, assert both -> level becomes 1, `underflow_o`=1, and the pushed word is visible on the read data the next cycle.
- **Clear:** at level 9 with `overflow_o` set, pulse `clear_i` together with a push -> level 0, `empty_o`=1, errors 0, `mem_write_en_o`=0 in that cycle.

Source files
------------

// File: rtl/fifo_ctrl_block.sv
// fifo_ctrl_block
// Single-clock pointer and flag controller for a first-word-fall-through
// FIFO memory. Owns the write/read pointers, gates memory writes against
// full, pops against empty, and reports level, threshold flags and sticky
// overflow/underflow errors.

module fifo_ctrl_block #(
    parameter int unsigned addr_size          = 4,
    parameter int unsigned almost_full_level  = 12,
    parameter int unsigned almost_empty_level = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 write_en_i,
    input  logic                 read_en_i,
    output logic                 mem_write_en_o,
    output logic [addr_size-1:0] write_addr_o,
    output logic [addr_size-1:0] read_addr_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [addr_size:0]   level_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    // Thresholds narrowed once to the level width so the compares below
    // are width-matched; legal values (<= depth) always fit.
    localparam logic [addr_size:0] AF_LEVEL = almost_full_level[addr_size:0];
    localparam logic [addr_size:0] AE_LEVEL = almost_empty_level[addr_size:0];

    // Pointers carry one extra wrap bit above the address bits.
    logic [addr_size:0] r_wptr;
    logic [addr_size:0] r_rptr;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic [addr_size:0] w_level;
    logic               w_push;
    logic               w_pop;
    logic               w_push_reject;
    logic               w_pop_reject;

    // Flags and level derived combinationally from the registered pointers.
    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[addr_size] != r_rptr[addr_size]) &&
                  (r_wptr[addr_size-1:0] == r_rptr[addr_size-1:0]);
        w_level = r_wptr - r_rptr;
    end

    // Request qualification; clear discards requests without flagging errors.
    always_comb begin
        w_push        = write_en_i & ~w_full;
        w_pop         = read_en_i & ~w_empty;
        w_push_reject = write_en_i & w_full & ~clear_i;
        w_pop_reject  = read_en_i & w_empty & ~clear_i;
    end

    // Pointer registers: reset over clear over push/pop.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Sticky error flags, held until reset or clear.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_reject) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_reject) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Output drive; memory write is gated by the same full used for push.
    always_comb begin
        mem_write_en_o = write_en_i & ~w_full & ~clear_i;
        write_addr_o   = r_wptr[addr_size-1:0];
        read_addr_o    = r_rptr[addr_size-1:0];
        full_o         = w_full;
        empty_o        = w_empty;
        level_o        = w_level;
        almost_full_o  = (w_level >= AF_LEVEL);
        almost_empty_o = (w_level <= AE_LEVEL);
        overflow_o     = r_overflow;
        underflow_o    = r_underflow;
    end

endmodule

// File: tb/tb_fifo_ctrl_block.sv
// tb_fifo_ctrl_block
// Scoreboard bench: the driver applies one request per cycle and pushes the
// expected response into queues; two monitors pop and compare. The reference
// is a plain queue of stored words plus push/pop counters. A small memory
// model in the bench turns the controller into a full FWFT FIFO so data order
// can be checked.

module tb_fifo_ctrl_block;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       clear_i = 1'b0;
    logic       write_en_i = 1'b0;
    logic       read_en_i = 1'b0;
    logic       mem_write_en_o;
    logic [AW-1:0] write_addr_o;
    logic [AW-1:0] read_addr_o;
    logic       full_o, empty_o, almost_full_o, almost_empty_o;
    logic [AW:0] level_o;
    logic       overflow_o, underflow_o;

    logic [7:0] wdata = 8'h00;
    logic [7:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    fifo_ctrl_block #(
        .addr_size(AW),
        .almost_full_level(12),
        .almost_empty_level(2)
    ) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .clear_i(clear_i),
        .write_en_i(write_en_i),
        .read_en_i(read_en_i),
        .mem_write_en_o(mem_write_en_o),
        .write_addr_o(write_addr_o),
        .read_addr_o(read_addr_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .level_o(level_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    // Memory model: one write port, combinational read port.
    always @(posedge clk) begin
        if (mem_write_en_o) mem[write_addr_o] <= wdata;
    end

    typedef struct {
        int         level;
        bit         ovf;
        bit         unf;
        int         waddr;
        int         raddr;
        bit         has_front;
        logic [7:0] front;
    } exp_t;

    bit   q_mwe[$];
    exp_t q_post[$];

    // Reference model state
    logic [7:0] m_q[$];
    bit m_ovf = 0, m_unf = 0;
    int m_pushes = 0, m_pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus expected responses.
    task automatic drive(input bit we, input bit re, input bit clr, input bit rst, input logic [7:0] d);
        bit   full, empty;
        exp_t e;
        @(negedge clk);
        write_en_i = we;
        read_en_i  = re;
        clear_i    = clr;
        reset_i    = rst;
        wdata      = d;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        q_mwe.push_back(we && !full && !clr);
        if (rst || clr) begin
            m_q.delete();
            m_ovf = 0; m_unf = 0; m_pushes = 0; m_pops = 0;
        end else begin
            if (we && full) m_ovf = 1;
            if (re && empty) m_unf = 1;
            if (re && !empty) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (we && !full) begin
                m_q.push_back(d);
                m_pushes++;
            end
        end
        e.level     = m_q.size();
        e.ovf       = m_ovf;
        e.unf       = m_unf;
        e.waddr     = m_pushes % DEPTH;
        e.raddr     = m_pops % DEPTH;
        e.has_front = (m_q.size() != 0);
        e.front     = e.has_front ? m_q[0] : 8'h00;
        q_post.push_back(e);
    endtask

    // Combinational memory write enable, checked mid-cycle after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q_mwe.size() != 0) chk("mem_write_en", 32'(mem_write_en_o), 32'(q_mwe.pop_front()));
        end
    end

    // Post-edge state and FWFT read data.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_post.size() != 0) begin
                e = q_post.pop_front();
                chk("level", 32'(level_o), 32'(e.level));
                chk("empty", 32'(empty_o), 32'(e.level == 0));
                chk("full", 32'(full_o), 32'(e.level == DEPTH));
                chk("almost_full", 32'(almost_full_o), 32'(e.level >= 12));
                chk("almost_empty", 32'(almost_empty_o), 32'(e.level <= 2));
                chk("overflow", 32'(overflow_o), 32'(e.ovf));
                chk("underflow", 32'(underflow_o), 32'(e.unf));
                chk("write_addr", 32'(write_addr_o), 32'(e.waddr));
                chk("read_addr", 32'(read_addr_o), 32'(e.raddr));
                if (e.has_front) chk("read_data", 32'(mem[read_addr_o]), 32'(e.front));
            end
        end
    end

    initial begin
        logic [7:0] d;
        // Reset held with random requests
        for (int i = 0; i < 2; i++) drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 0, 1, 8'($urandom));
        // Fill 0x00..0x0F, overflow push, drain in order
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 8'(i));
        drive(1, 0, 0, 0, 8'hAA);
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 0, 8'h00);
        // Wrap-around at level 5
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) drive(1, 1, 0, 0, 8'($urandom));
        // Full with push+pop
        for (int i = 0; i < 11; i++) drive(1, 0, 0, 0, 8'($urandom));
        drive(1, 1, 0, 0, 8'h5A);
        // Drain to empty, then push+pop at empty
        for (int i = 0; i < 15; i++) drive(0, 1, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 8'hC3);
        drive(0, 0, 0, 0, 8'h00);
        // Level 9 with overflow set, then clear alongside a push
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 17; i++) drive(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 7; i++) drive(0, 1, 0, 0, 8'h00);
        drive(1, 1, 1, 0, 8'h77);
        drive(0, 0, 0, 0, 8'h00);
        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            d = 8'($urandom);
            drive($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30),
                  $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70),
                  $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1, d);
        end
        drive(0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge clk);
        if (q_post.size() != 0 || q_mwe.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_post.size() + q_mwe.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
